// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data unified-memory arbiter.
// Imported by the arbiter top level and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FETCH,
    ARB_DATA
  } arb_state_t;

  typedef enum logic {
    PORT_FETCH,
    PORT_DATA
  } port_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side fetch/data ports and memory-side bus of the arbiter.
// slave is the arbiter's view; master is the pipeline plus memory environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-request round-robin picker: data wins a tie unless it won the previous grant.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic  req_f,
  input  logic  req_d,
  input  port_t last_grant,
  output logic  gnt_f,
  output logic  gnt_d
);

  assign gnt_d = req_d & (~req_f | (last_grant != PORT_DATA));
  assign gnt_f = req_f & (~req_d | (last_grant == PORT_DATA));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory between instruction fetch and data access,
// one transaction at a time, with registered one-cycle ready pulses.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mem_arbiter_if.slave bus
);

  arb_state_t state;
  arb_state_t stateNext;
  port_t      lastGrant;
  logic       killed;
  logic       fetchElig;
  logic       dataElig;
  logic       gntF;
  logic       gntD;

  // A port whose ready pulse is high right now has just been served.
  assign fetchElig = bus.if_req & ~bus.if_kill & ~bus.if_ready;
  assign dataElig  = bus.d_req & ~bus.d_ready;

  rr_arb2 picker (
    .req_f      (fetchElig),
    .req_d      (dataElig),
    .last_grant (lastGrant),
    .gnt_f      (gntF),
    .gnt_d      (gntD)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ARB_IDLE: begin
        if (gntD)      stateNext = ARB_DATA;
        else if (gntF) stateNext = ARB_FETCH;
      end
      ARB_FETCH, ARB_DATA: begin
        if (bus.mem_ack) stateNext = ARB_IDLE;
      end
      default: stateNext = ARB_IDLE;
    endcase
  end

  // Derived from state so an asynchronous reset drops the request at once.
  assign bus.mem_req = (state != ARB_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_ready  <= 1'b0;
      bus.d_ready   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      lastGrant     <= PORT_FETCH;
      killed        <= 1'b0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.d_ready  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (gntD) begin
            bus.mem_addr  <= bus.d_addr;
            bus.mem_we    <= bus.d_we;
            bus.mem_wdata <= bus.d_wdata;
            lastGrant     <= PORT_DATA;
          end else if (gntF) begin
            bus.mem_addr <= bus.if_addr;
            bus.mem_we   <= 1'b0;
            lastGrant    <= PORT_FETCH;
          end
        end
        // A kill seen on the ack edge still squashes the completing fetch.
        ARB_FETCH: begin
          if (bus.mem_ack) begin
            killed <= 1'b0;
            if (!(killed | bus.if_kill)) begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_ready <= 1'b1;
            end
          end else if (bus.if_kill) begin
            killed <= 1'b1;
          end
        end
        ARB_DATA: begin
          if (bus.mem_ack) begin
            bus.d_ready <= 1'b1;
            if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations
// plus a randomized pipeline/memory environment compared against a transaction model.
module tb_mem_arbiter;

  logic clk;
  logic reset;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory environment knobs
  int          memWait = 0;
  bit          randomWait = 0;
  bit          noiseAck = 0;
  bit          useFixedRdata = 0;
  logic [31:0] fixedRdata = '0;
  bit          memBusy = 0;
  int          memLeft = 0;

  // Random requester state
  bit fActive = 0;
  bit dActive = 0;

  // Transaction-level reference model
  bit        mBusy, mOwnerData, mWe, mSquashed, mLastData;
  bit [31:0] mAddr, mWdata;
  bit        mIfReady, mDReady;
  bit [31:0] mIfRdata, mDRdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.if_kill = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic applyReset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // One cycle of a randomized pipeline: requests held until ready, fetch may be squashed.
  task automatic applyStimulus;
    bus.if_kill = 1'b0;
    if (fActive && bus.if_ready) fActive = 0;
    if (dActive && bus.d_ready)  dActive = 0;
    if ($urandom_range(0, 11) == 0) begin
      bus.if_kill = 1'b1;
      fActive = $urandom_range(0, 1) == 1;
      if (fActive) bus.if_addr = $urandom & 32'hFFFF_FFFC;
    end else if (!fActive && $urandom_range(0, 2) == 0) begin
      fActive = 1;
      bus.if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!dActive && $urandom_range(0, 2) == 0) begin
      dActive = 1;
      bus.d_we    = $urandom_range(0, 1) == 1;
      bus.d_addr  = $urandom & 32'hFFFF_FFFC;
      bus.d_wdata = $urandom;
    end
    bus.if_req = fActive;
    bus.d_req  = dActive;
  endtask

  // Memory responder: acks after memWait (or random) extra cycles, optional stray acks while idle.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        memBusy = 0;
        bus.mem_ack = 1'b0;
      end else begin
        if (memBusy && bus.mem_ack) memBusy = 0;
        bus.mem_ack = 1'b0;
        if (bus.mem_req && !memBusy) begin
          memBusy = 1;
          memLeft = randomWait ? int'($urandom_range(0, 3)) : memWait;
        end
        if (memBusy) begin
          if (memLeft == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = useFixedRdata ? fixedRdata : $urandom;
          end else begin
            memLeft--;
          end
        end else if (noiseAck && $urandom_range(0, 3) == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = $urandom;
        end
      end
    end
  end

  // Reference model: one transaction in flight; served port's ready pulses the cycle after ack.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mBusy = 0; mOwnerData = 0; mWe = 0; mSquashed = 0; mLastData = 0;
        mAddr = 0; mWdata = 0; mIfReady = 0; mDReady = 0; mIfRdata = 0; mDRdata = 0;
      end else begin
        bit newIf, newD, wantF, wantD;
        newIf = 0;
        newD  = 0;
        if (mBusy) begin
          if (!mOwnerData && bus.if_kill) mSquashed = 1;
          if (bus.mem_ack) begin
            mBusy = 0;
            if (mOwnerData) begin
              newD = 1;
              if (!mWe) mDRdata = bus.mem_rdata;
            end else if (!mSquashed) begin
              newIf = 1;
              mIfRdata = bus.mem_rdata;
            end
            mSquashed = 0;
          end
        end else begin
          wantF = bus.if_req && !bus.if_kill && !mIfReady;
          wantD = bus.d_req && !mDReady;
          if (wantD && (!wantF || !mLastData)) begin
            mBusy = 1; mOwnerData = 1; mLastData = 1;
            mWe = bus.d_we; mAddr = bus.d_addr; mWdata = bus.d_wdata;
          end else if (wantF) begin
            mBusy = 1; mOwnerData = 0; mLastData = 0;
            mWe = 0; mAddr = bus.if_addr;
          end
        end
        mIfReady = newIf;
        mDReady  = newD;
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model mem_req", bus.mem_req, mBusy);
      if (mBusy) begin
        checkOutput("model mem_addr", bus.mem_addr, mAddr);
        checkOutput("model mem_we", bus.mem_we, mWe);
        if (mOwnerData) checkOutput("model mem_wdata", bus.mem_wdata, mWdata);
      end
      checkOutput("model if_ready", bus.if_ready, mIfReady);
      checkOutput("model d_ready", bus.d_ready, mDReady);
      checkOutput("model if_rdata", bus.if_rdata, mIfRdata);
      checkOutput("model d_rdata", bus.d_rdata, mDRdata);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    clearInputs();
    #1;

    // Single fetch, zero wait
    useFixedRdata = 1;
    fixedRdata = 32'h0050_0093;
    memWait = 0;
    applyReset();
    checkOutput("reset mem_req", bus.mem_req, 0);
    checkOutput("reset if_ready", bus.if_ready, 0);
    checkOutput("reset mem_addr", bus.mem_addr, 0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    tick;
    checkOutput("fetch1 mem_req", bus.mem_req, 1);
    checkOutput("fetch1 mem_addr", bus.mem_addr, 32'h100);
    checkOutput("fetch1 mem_we", bus.mem_we, 0);
    checkOutput("fetch1 early if_ready", bus.if_ready, 0);
    tick;
    checkOutput("fetch1 if_ready", bus.if_ready, 1);
    checkOutput("fetch1 if_rdata", bus.if_rdata, 32'h0050_0093);
    checkOutput("fetch1 mem_req drop", bus.mem_req, 0);
    bus.if_req = 1'b0;
    tick;
    checkOutput("fetch1 pulse width", bus.if_ready, 0);

    // Store with three wait cycles
    clearInputs();
    memWait = 3;
    applyReset();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h2000;
    bus.d_wdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 4; k++) begin
      tick;
      checkOutput("store mem_req", bus.mem_req, 1);
      checkOutput("store mem_we", bus.mem_we, 1);
      checkOutput("store mem_addr", bus.mem_addr, 32'h2000);
      checkOutput("store mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      checkOutput("store early d_ready", bus.d_ready, 0);
    end
    tick;
    checkOutput("store d_ready", bus.d_ready, 1);
    checkOutput("store d_rdata kept", bus.d_rdata, 0);
    checkOutput("store mem_req drop", bus.mem_req, 0);
    bus.d_req = 1'b0;
    tick;

    // Continuous contention from reset
    clearInputs();
    memWait = 0;
    useFixedRdata = 0;
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h1000;
    applyReset();
    for (int k = 1; k <= 8; k++) begin
      tick;
      checkOutput("contend d_ready", bus.d_ready, (k == 2 || k == 6) ? 1 : 0);
      checkOutput("contend if_ready", bus.if_ready, (k == 4 || k == 8) ? 1 : 0);
      if (k == 1) checkOutput("contend first grant addr", bus.mem_addr, 32'h1000);
      if (k == 3) checkOutput("contend second grant addr", bus.mem_addr, 32'h0);
      if (bus.d_ready)  bus.d_addr  = bus.d_addr + 32'd4;
      if (bus.if_ready) bus.if_addr = bus.if_addr + 32'd4;
    end
    clearInputs();
    tick;
    tick;

    // Kill while a fetch is in flight
    clearInputs();
    memWait = 3;
    useFixedRdata = 1;
    fixedRdata = 32'hBAD0_BAD0;
    applyReset();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    tick;
    checkOutput("kill mem_addr", bus.mem_addr, 32'h40);
    tick;
    bus.if_kill = 1'b1;
    bus.if_req  = 1'b0;
    tick;
    bus.if_kill = 1'b0;
    checkOutput("kill still in flight", bus.mem_req, 1);
    tick;
    tick;
    checkOutput("kill no if_ready", bus.if_ready, 0);
    checkOutput("kill if_rdata kept", bus.if_rdata, 0);
    checkOutput("kill back to idle", bus.mem_req, 0);
    memWait = 0;
    fixedRdata = 32'h00A0_0113;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    tick;
    checkOutput("kill next mem_addr", bus.mem_addr, 32'h80);
    tick;
    checkOutput("kill next if_ready", bus.if_ready, 1);
    checkOutput("kill next if_rdata", bus.if_rdata, 32'h00A0_0113);
    bus.if_req = 1'b0;
    tick;

    // Kill in an idle cycle blocks the grant for that cycle
    clearInputs();
    memWait = 0;
    applyReset();
    bus.if_req  = 1'b1;
    bus.if_kill = 1'b1;
    bus.if_addr = 32'h300;
    tick;
    checkOutput("idle kill no grant", bus.mem_req, 0);
    bus.if_kill = 1'b0;
    tick;
    checkOutput("idle kill then grant", bus.mem_req, 1);
    checkOutput("idle kill grant addr", bus.mem_addr, 32'h300);
    tick;
    checkOutput("idle kill if_ready", bus.if_ready, 1);
    bus.if_req = 1'b0;
    tick;

    // Asynchronous reset while a load waits
    clearInputs();
    memWait = 3;
    fixedRdata = 32'h0000_1234;
    applyReset();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h3000;
    tick;
    checkOutput("rstmid mem_req before", bus.mem_req, 1);
    tick;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstmid mem_req", bus.mem_req, 0);
    checkOutput("rstmid mem_addr", bus.mem_addr, 0);
    checkOutput("rstmid mem_we", bus.mem_we, 0);
    checkOutput("rstmid d_ready", bus.d_ready, 0);
    checkOutput("rstmid d_rdata", bus.d_rdata, 0);
    bus.d_req = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      checkOutput("rstmid no d_ready", bus.d_ready, 0);
      checkOutput("rstmid stays idle", bus.mem_req, 0);
    end

    // Randomized traffic against the model
    clearInputs();
    useFixedRdata = 0;
    randomWait = 1;
    noiseAck = 1;
    fActive = 0;
    dActive = 0;
    applyReset();
    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      tick;
    end
    clearInputs();
    noiseAck = 0;
    repeat (10) tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
